// File: rtl/dmc_req_sequencer.sv
// Request FIFO and issue sequencer in front of a dual-memory controller.
// Queues host requests, inserts a bubble on read/write turnaround, returns reads.
module dmc_req_sequencer #(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic                       req_sel,
    input  logic [7:0]                 req_addr,
    input  logic [7:0]                 req_wdata,
    output logic                       mem_select,
    output logic                       write_enable,
    output logic [7:0]                 data_ex,
    output logic [7:0]                 add_ex,
    input  logic [7:0]                 data_out,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_data,
    output logic                       rsp_sel,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    logic [17:0]       fifo [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_nxt;
    logic [LW-1:0]     level_q;
    logic              ready_en;
    logic [1:0]        state;
    logic [1:0]        state_d;
    logic              push;
    logic              pop;
    logic [17:0]       head;
    logic              has_nxt;
    logic              nxt_we;
    logic [RD_LAT-1:0] rd_v;
    logic [RD_LAT-1:0] rd_s;

    assign req_ready = ready_en && (level_q < LW'(DEPTH));
    assign level     = level_q;
    assign push      = req_valid && req_ready;
    assign pop       = (state == ISSUE);
    assign rd_nxt    = rd_ptr + AW'(1);
    assign head      = fifo[rd_ptr];

    // The entry behind the head may be the one being pushed right now.
    assign has_nxt = (level_q > LW'(1)) || push;
    assign nxt_we  = (level_q > LW'(1)) ? fifo[rd_nxt][17] : req_we;

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {req_we, req_sel, req_addr, req_wdata};
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (level_q != '0) state_d = ISSUE;
            ISSUE: begin
                if (!has_nxt)              state_d = IDLE;
                else if (nxt_we != head[17]) state_d = TURN;
                else                       state_d = ISSUE;
            end
            TURN:    state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_d;
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_nxt;
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_enable <= 1'b0;
            mem_select   <= 1'b0;
            add_ex       <= '0;
            data_ex      <= '0;
        end else begin
            write_enable <= pop && head[17];
            if (pop) begin
                mem_select <= head[16];
                add_ex     <= head[15:8];
                data_ex    <= head[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v      <= '0;
            rd_s      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_sel   <= 1'b0;
        end else begin
            rd_v[0] <= pop && !head[17];
            rd_s[0] <= head[16];
            for (int i = 1; i < RD_LAT; i++) begin
                rd_v[i] <= rd_v[i-1];
                rd_s[i] <= rd_s[i-1];
            end
            rsp_valid <= rd_v[RD_LAT-1];
            if (rd_v[RD_LAT-1]) begin
                rsp_data <= data_out;
                rsp_sel  <= rd_s[RD_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_dmc_req_sequencer.sv
// Directed bench for dmc_req_sequencer with a small two-memory controller model.
module tb_dmc_req_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic       req_sel;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       mem_select;
    logic       write_enable;
    logic [7:0] data_ex;
    logic [7:0] add_ex;
    logic [7:0] data_out;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_sel;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    dmc_req_sequencer #(.DEPTH(4), .RD_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_sel(req_sel),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_select(mem_select), .write_enable(write_enable),
        .data_ex(data_ex), .add_ex(add_ex), .data_out(data_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sel(rsp_sel),
        .level(level)
    );

    always #5 clk = ~clk;

    // Controller model: memory A is writable, memory B reads back 0xB0+addr.
    logic [7:0] mem_a [256];
    logic [7:0] p0, p1;
    assign data_out = p1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write_enable && !mem_select) mem_a[add_ex] <= data_ex;
        p0 <= mem_select ? (8'hB0 + add_ex) : mem_a[add_ex];
        p1 <= p0;
    end

    logic [8:0]  rsp_q [$];
    int          rsp_t [$];
    logic [16:0] wr_q  [$];

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_q.push_back({rsp_sel, rsp_data});
            rsp_t.push_back(cyc);
        end
        if (write_enable === 1'b1) wr_q.push_back({mem_select, add_ex, data_ex});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic sel,
                         input logic [7:0] a, input logic [7:0] d);
        req_valid = v;
        req_we    = we;
        req_sel   = sel;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic clear_logs();
        rsp_q.delete();
        rsp_t.delete();
        wr_q.delete();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [16:0] exp_wr [4];
    logic [8:0]  exp_rs [4];
    logic [7:0]  lv_exp [5];
    logic        rdy_before;
    int          stalls;
    int          idx;
    int          saw_full;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_level", level, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_addr", add_ex, 0);
        chk("rst_rsp", {rsp_valid, rsp_sel, rsp_data}, 0);
        rst_n = 1'b1;
        chk("ready_pre_edge", req_ready, 0);
        tick();
        chk("ready_post_edge", req_ready, 1);

        // Write A 0x10=0x5A then read it back
        clear_logs();
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h5A);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        tick();
        chk("t1_level2", level, 2);
        chk("t1_no_bypass", write_enable, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("t1_wr_pulse", {write_enable, mem_select, add_ex, data_ex}, 18'h2105A);
        chk("t1_level1", level, 1);
        tick();
        chk("t1_turn_we", write_enable, 0);
        chk("t1_turn_level", level, 1);
        tick();
        chk("t1_rd_issue", {write_enable, add_ex, level}, {1'b0, 8'h10, 3'd0});
        tick();
        chk("t1_rsp_e6", rsp_valid, 0);
        tick();
        chk("t1_rsp_e7", rsp_valid, 0);
        tick();
        chk("t1_rsp_e8", {rsp_valid, rsp_sel, rsp_data}, {1'b1, 1'b0, 8'h5A});
        tick();
        chk("t1_rsp_e9", rsp_valid, 0);
        idle(4);

        // Five back-to-back writes, never stalled, pop and push together at level 2
        clear_logs();
        lv_exp[0] = 1; lv_exp[1] = 2; lv_exp[2] = 2; lv_exp[3] = 2; lv_exp[4] = 2;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h30 + 8'(i), 8'h40 + 8'(i));
            chk($sformatf("t2_ready%0d", i), req_ready, 1);
            tick();
            chk($sformatf("t2_level%0d", i), level, lv_exp[i]);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("t2_level_drain1", level, 1);
        tick();
        chk("t2_level_drain0", level, 0);
        idle(4);
        chk("t2_wr_count", wr_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2_wr%0d", i), (i < wr_q.size()) ? wr_q[i] : 17'h1FFFF,
                {1'b0, 8'h30 + 8'(i), 8'h40 + 8'(i)});
        chk("t2_no_rsp", rsp_q.size(), 0);

        // Alternating traffic fills the FIFO and stalls one push
        clear_logs();
        stalls = 0;
        saw_full = 0;
        idx = 0;
        for (int n = 0; n < 40 && idx < 7; n++) begin
            if (idx[0] == 1'b0)
                drive(1'b1, 1'b1, 1'b0, 8'h50 + 8'(idx / 2), 8'h60 + 8'(idx / 2));
            else
                drive(1'b1, 1'b0, 1'b0, 8'h50 + 8'(idx / 2), 8'h00);
            rdy_before = req_ready;
            tick();
            if (rdy_before) idx++;
            else stalls++;
            chk($sformatf("t3_ready_rel%0d", n), req_ready, (level < 3'd4));
            if (level == 3'd4) saw_full++;
        end
        chk("t3_all_pushed", idx, 7);
        chk("t3_stalls", stalls, 1);
        chk("t3_full_seen", saw_full > 0, 1);
        idle(24);
        chk("t3_level_end", level, 0);
        for (int i = 0; i < 4; i++) exp_wr[i] = {1'b0, 8'h50 + 8'(i), 8'h60 + 8'(i)};
        chk("t3_wr_count", wr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_wr%0d", i), (i < wr_q.size()) ? wr_q[i] : 17'h1FFFF, exp_wr[i]);
        chk("t3_rsp_count", rsp_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t3_rsp%0d", i), (i < rsp_q.size()) ? rsp_q[i] : 9'h1FF,
                {1'b0, 8'h60 + 8'(i)});

        // Four reads of B back-to-back
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h01 + 8'(i), 8'h00);
            tick();
        end
        idle(10);
        for (int i = 0; i < 4; i++) exp_rs[i] = {1'b1, 8'hB1 + 8'(i)};
        chk("t4_rsp_count", rsp_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_rsp%0d", i), (i < rsp_q.size()) ? rsp_q[i] : 9'h000, exp_rs[i]);
        for (int i = 1; i < 4; i++)
            chk($sformatf("t4_b2b%0d", i),
                (i < rsp_t.size()) ? rsp_t[i] - rsp_t[i-1] : 0, 1);

        // W,R,W,R: a bubble at every turnaround
        clear_logs();
        drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h11);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h21, 8'h22);
        tick();
        chk("t5_we_e3", write_enable, 1);
        drive(1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
        tick();
        chk("t5_we_e4", write_enable, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("t5_we_e5", write_enable, 0);
        tick();
        chk("t5_we_e6", write_enable, 0);
        tick();
        chk("t5_we_e7", {write_enable, add_ex, data_ex}, {1'b1, 8'h21, 8'h22});
        tick();
        chk("t5_we_e8", write_enable, 0);
        tick();
        chk("t5_we_e9", {write_enable, add_ex, level}, {1'b0, 8'h21, 3'd0});
        idle(6);
        chk("t5_rsp_count", rsp_q.size(), 2);
        chk("t5_rsp0", (rsp_q.size() > 0) ? rsp_q[0] : 9'h1FF, 9'h011);
        chk("t5_rsp1", (rsp_q.size() > 1) ? rsp_q[1] : 9'h1FF, 9'h022);

        // Reset with three queued and two reads in flight
        drive(1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'h02, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h70, 8'h71);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h72, 8'h73);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h74, 8'h75);
        tick();
        chk("t6_level_pre", level, 3);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        clear_logs();
        #1;
        chk("t6_async_level", level, 0);
        chk("t6_async_out", {req_ready, write_enable, mem_select, add_ex, data_ex}, 0);
        tick();
        tick();
        chk("t6_rst_rsp", {rsp_valid, rsp_sel, rsp_data}, 0);
        rst_n = 1'b1;
        idle(10);
        chk("t6_level_post", level, 0);
        chk("t6_no_rsp", rsp_q.size(), 0);
        chk("t6_no_wr", wr_q.size(), 0);
        drive(1'b1, 1'b0, 1'b1, 8'h03, 8'h00);
        tick();
        idle(8);
        chk("t6_new_count", rsp_q.size(), 1);
        chk("t6_new_rsp", (rsp_q.size() > 0) ? rsp_q[0] : 9'h000, 9'h1B3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
